// File: rtl/prescaled_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prescaled_counter_pkg : shared defaults and limit-kind constants
// Revision 1.0
// ---------------------------------------------------------------------------
package prescaled_counter_pkg;

    localparam int DEFAULT_WIDTH         = 16;
    localparam int DEFAULT_PRESCALE_BITS = 1;

    // Values accepted by the SATURATE parameter
    localparam int WRAP  = 0;
    localparam int CLAMP = 1;

    localparam int DEFAULT_SATURATE = WRAP;

endpackage : prescaled_counter_pkg
`default_nettype wire

// File: rtl/prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prescaler : free-running enable divider, tick_en once per 2^PRESCALE_BITS
// Revision 1.0
// ---------------------------------------------------------------------------
module prescaler
    import prescaled_counter_pkg::*;
#(
    parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
    input  logic clock,
    input  logic reset_,
    input  logic enable,
    input  logic clear,
    output logic tick_en
);

    generate
        if (PRESCALE_BITS == 0) begin : g_bypass
            assign tick_en = enable && !clear;
        end else begin : g_count
            logic [PRESCALE_BITS-1:0] r_count;

            always_ff @(posedge clock) begin
                if (reset_) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Event fires on the enabled cycle that rolls the count over
            assign tick_en = enable && !clear && (&r_count);
        end
    endgenerate

endmodule : prescaler
`default_nettype wire

// File: rtl/prescaled_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prescaled_counter : up/down counter with prescaled stepping, wrap or clamp
// Revision 1.0
// ---------------------------------------------------------------------------
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS,
    parameter int SATURATE      = DEFAULT_SATURATE
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             enable,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             limit
);

    logic             w_step_event;
    logic [WIDTH:0]   w_sum;
    logic             w_overflow;
    logic [WIDTH-1:0] w_next;

    prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clock   (clock),
        .reset_  (reset_),
        .enable  (enable),
        .clear   (load),
        .tick_en (w_step_event)
    );

    // The extra MSB carries out on increment and goes high on borrow
    always_comb begin
        w_sum      = up ? ({1'b0, out} + {1'b0, step})
                        : ({1'b0, out} - {1'b0, step});
        w_overflow = w_sum[WIDTH];
        w_next     = w_sum[WIDTH-1:0];
        if (w_overflow && (SATURATE == CLAMP)) begin
            w_next = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            out   <= '0;
            tick  <= 1'b0;
            limit <= 1'b0;
        end else if (load) begin
            out   <= load_value;
            tick  <= 1'b0;
            limit <= 1'b0;
        end else if (w_step_event) begin
            out   <= w_next;
            tick  <= 1'b1;
            limit <= w_overflow;
        end else begin
            tick  <= 1'b0;
            limit <= 1'b0;
        end
    end

endmodule : prescaled_counter
`default_nettype wire

// File: tb/tb_prescaled_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prescaled_counter : three configurations against an arithmetic model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_prescaled_counter;
    import prescaled_counter_pkg::*;

    localparam int     W    = 16;
    localparam longint MAXV = (longint'(1) << W) - 1;

    logic         clock = 1'b0;
    logic         reset_;
    logic         enable;
    logic         up;
    logic         load;
    logic [W-1:0] step;
    logic [W-1:0] load_value;

    logic [W-1:0] out_a, out_b, out_c;
    logic         tick_a, tick_b, tick_c;
    logic         limit_a, limit_b, limit_c;

    always #5 clock = ~clock;

    prescaled_counter #(.WIDTH(W), .PRESCALE_BITS(1), .SATURATE(WRAP)) u_wrap (
        .clock(clock), .reset_(reset_), .enable(enable), .up(up), .step(step),
        .load(load), .load_value(load_value), .out(out_a), .tick(tick_a), .limit(limit_a));

    prescaled_counter #(.WIDTH(W), .PRESCALE_BITS(1), .SATURATE(CLAMP)) u_clamp (
        .clock(clock), .reset_(reset_), .enable(enable), .up(up), .step(step),
        .load(load), .load_value(load_value), .out(out_b), .tick(tick_b), .limit(limit_b));

    prescaled_counter #(.WIDTH(W), .PRESCALE_BITS(0), .SATURATE(WRAP)) u_fast (
        .clock(clock), .reset_(reset_), .enable(enable), .up(up), .step(step),
        .load(load), .load_value(load_value), .out(out_c), .tick(tick_c), .limit(limit_c));

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = u_wrap, 1 = u_clamp, 2 = u_fast
    int     psc [3] = '{1, 1, 0};
    int     sat [3] = '{0, 1, 0};
    longint m_out [3];
    int     m_pc  [3];
    bit     m_tick[3];
    bit     m_lim [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_update();
        longint r;
        for (int k = 0; k < 3; k++) begin
            m_tick[k] = 1'b0;
            m_lim[k]  = 1'b0;
            if (reset_) begin
                m_out[k] = 0;
                m_pc[k]  = 0;
            end else if (load) begin
                m_out[k] = longint'(load_value);
                m_pc[k]  = 0;
            end else if (enable) begin
                m_pc[k]++;
                if (m_pc[k] == (1 << psc[k])) begin
                    m_pc[k]   = 0;
                    m_tick[k] = 1'b1;
                    r = up ? m_out[k] + longint'(step) : m_out[k] - longint'(step);
                    if (r > MAXV) begin
                        m_lim[k] = 1'b1;
                        m_out[k] = (sat[k] != 0) ? MAXV : r - (MAXV + 1);
                    end else if (r < 0) begin
                        m_lim[k] = 1'b1;
                        m_out[k] = (sat[k] != 0) ? 0 : r + (MAXV + 1);
                    end else begin
                        m_out[k] = r;
                    end
                end
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_update();
        #1;
        check("wrap.out",    32'(out_a),   32'(m_out[0]));
        check("wrap.tick",   32'(tick_a),  32'(m_tick[0]));
        check("wrap.limit",  32'(limit_a), 32'(m_lim[0]));
        check("clamp.out",   32'(out_b),   32'(m_out[1]));
        check("clamp.tick",  32'(tick_b),  32'(m_tick[1]));
        check("clamp.limit", 32'(limit_b), 32'(m_lim[1]));
        check("fast.out",    32'(out_c),   32'(m_out[2]));
        check("fast.tick",   32'(tick_c),  32'(m_tick[2]));
        check("fast.limit",  32'(limit_c), 32'(m_lim[2]));
    endtask

    function automatic logic [W-1:0] pick_value();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return {W{1'b1}};
            2:       return W'($urandom_range(0, 7));
            3:       return {W{1'b1}} - W'($urandom_range(0, 7));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset_ = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0;
        step = '0; load_value = '0;
        for (int k = 0; k < 3; k++) begin
            m_out[k] = 0; m_pc[k] = 0; m_tick[k] = 0; m_lim[k] = 0;
        end
        cycle();
        cycle();
        check("reset.out", 32'(out_a), 32'h0);

        // Prescale by 2 from reset: out seen at the start of each enabled cycle
        reset_ = 1'b0; enable = 1'b1; up = 1'b1; step = 16'd1;
        for (int i = 1; i <= 8; i++) begin
            check("seq.out", 32'(out_a), 32'(i - 1) / 2);
            cycle();
            check("seq.tick", 32'(tick_a), 32'((i % 2) == 0));
        end

        // Carry out of the top: wrap to 1 with a single-cycle limit pulse
        load = 1'b1; load_value = 16'hFFFE; enable = 1'b0;
        cycle();
        load = 1'b0; enable = 1'b1; step = 16'd3; up = 1'b1;
        cycle();
        cycle();
        check("carry.out",   32'(out_a),   32'h0001);
        check("carry.limit", 32'(limit_a), 32'h1);
        check("carry.clamp", 32'(out_b),   32'hFFFF);
        enable = 1'b0;
        cycle();
        check("carry.limit_gone", 32'(limit_a), 32'h0);

        // Borrow with clamping, twice, including from an already-zero count
        load = 1'b1; load_value = 16'h0002;
        cycle();
        load = 1'b0; enable = 1'b1; up = 1'b0; step = 16'd5;
        for (int t = 0; t < 2; t++) begin
            cycle();
            cycle();
            check("clamp0.out",   32'(out_b),   32'h0);
            check("clamp0.limit", 32'(limit_b), 32'h1);
        end

        // Load landing on a step-event cycle restarts the prescale
        up = 1'b1; step = 16'd1;
        load = 1'b1; load_value = 16'h0000;
        cycle();
        load = 1'b0;
        cycle();
        load = 1'b1; load_value = 16'h1234;
        cycle();
        check("ldevt.out",  32'(out_a),  32'h1234);
        check("ldevt.tick", 32'(tick_a), 32'h0);
        load = 1'b0;
        cycle();
        check("ldevt.tick1", 32'(tick_a), 32'h0);
        cycle();
        check("ldevt.tick2", 32'(tick_a), 32'h1);

        // Reset beats load and enable
        reset_ = 1'b1; load = 1'b1; load_value = 16'hBEEF;
        cycle();
        check("rstpri.out",   32'(out_a),   32'h0);
        check("rstpri.tick",  32'(tick_a),  32'h0);
        check("rstpri.limit", 32'(limit_a), 32'h0);

        // No prescale: enable 1,0,1 with step 2
        reset_ = 1'b0; load = 1'b0; up = 1'b1; step = 16'd2;
        for (int i = 0; i < 3; i++) begin
            enable = (i != 1);
            cycle();
            check("fast.seq.out",  32'(out_c),  (i == 2) ? 32'd4 : 32'd2);
            check("fast.seq.tick", 32'(tick_c), 32'(i != 1));
        end

        // Zero step still ticks without limit
        step = '0; enable = 1'b1;
        cycle();
        check("zero.tick",  32'(tick_c),  32'h1);
        check("zero.limit", 32'(limit_c), 32'h0);

        for (int n = 0; n < 600; n++) begin
            reset_     = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 9) == 0);
            enable     = ($urandom_range(0, 9) < 7);
            up         = 1'($urandom);
            step       = pick_value();
            load_value = pick_value();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prescaled_counter
`default_nettype wire
